// File: rtl/proc_trace_pkg.sv
// rtl/proc_trace_pkg.sv - shared types and defaults for the processor trace buffer
package proc_trace_pkg;

    localparam logic [15:0] HALT_INSTR_DEFAULT = 16'h5000;

    typedef struct packed {
        logic [6:0]  pc;
        logic [15:0] ir;
    } trace_entry_t;

    typedef enum logic {
        CAPTURE,
        HALTED
    } trace_state_t;

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - DEPTH x 23 trace storage, synchronous write, asynchronous read
module trace_ram
    import proc_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     Clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  trace_entry_t             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output trace_entry_t             rd_data
);

    trace_entry_t mem [DEPTH];

    // No reset on the array: the top gates Rd_Data to zero whenever it is empty.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/proc_trace_buffer.sv
// rtl/proc_trace_buffer.sv - decode-entry instruction trace capture with halt freeze and valid/ready drain
module proc_trace_buffer
    import proc_trace_pkg::*;
#(
    parameter int          DEPTH        = 16,
    parameter logic [3:0]  DECODE_STATE = 4'h2,
    parameter logic [15:0] HALT_INSTR   = HALT_INSTR_DEFAULT
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Clr,
    input  logic [3:0]             State,
    input  logic [6:0]             PC_Out,
    input  logic [15:0]            IR_Out,
    input  logic                   Rd_Ready,
    output logic                   Rd_Valid,
    output logic [22:0]            Rd_Data,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Halted,
    output logic                   Overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    trace_state_t fsm, fsm_next;
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count_q;
    logic [3:0]    prev_state;
    logic          ovf_q;
    logic          cap, pop, full, wr_en;
    trace_entry_t  wr_entry, rd_entry;

    assign cap      = (State == DECODE_STATE) && (prev_state != DECODE_STATE) && (fsm == CAPTURE);
    assign pop      = Rd_Valid && Rd_Ready;
    assign full     = (count_q == CW'(DEPTH));
    assign wr_en    = cap && !Clr;
    assign wr_entry = '{pc: PC_Out, ir: IR_Out};

    always_comb begin
        fsm_next = fsm;
        if (Clr) begin
            fsm_next = CAPTURE;
        end else if (cap && (IR_Out == HALT_INSTR)) begin
            fsm_next = HALTED;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fsm        <= CAPTURE;
            prev_state <= 4'h0;
        end else begin
            fsm        <= fsm_next;
            prev_state <= State;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (Clr) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (cap) begin
                tail <= tail + AW'(1);
            end
            // A capture into a full buffer with no pop evicts the oldest entry.
            if (pop || (cap && full)) begin
                head <= head + AW'(1);
            end
            if (cap && full && !pop) begin
                ovf_q <= 1'b1;
            end
            if (cap && !pop && !full) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !cap) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    trace_ram #(.DEPTH(DEPTH)) u_ram (
        .Clk     (Clk),
        .wr_en   (wr_en),
        .wr_addr (tail),
        .wr_data (wr_entry),
        .rd_addr (head),
        .rd_data (rd_entry)
    );

    assign Rd_Valid = (count_q != '0);
    assign Rd_Data  = Rd_Valid ? rd_entry : 23'h0;
    assign Count    = count_q;
    assign Halted   = (fsm == HALTED);
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_proc_trace_buffer.sv
// tb/tb_proc_trace_buffer.sv - self-checking bench for proc_trace_buffer against a queue model
module tb_proc_trace_buffer;

    logic        clk = 1'b0;
    logic        reset, clr, rd_ready;
    logic [3:0]  state;
    logic [6:0]  pc;
    logic [15:0] ir;
    logic        rd_valid, halted, overflow;
    logic [22:0] rd_data;
    logic [4:0]  count;

    int checks = 0;
    int failures = 0;

    logic [22:0] m_q[$];
    bit          m_halted, m_ovf;
    logic [3:0]  m_prev;

    always #5 clk = ~clk;

    proc_trace_buffer dut (
        .Clk(clk), .Reset(reset), .Clr(clr), .State(state), .PC_Out(pc), .IR_Out(ir),
        .Rd_Ready(rd_ready), .Rd_Valid(rd_valid), .Rd_Data(rd_data), .Count(count),
        .Halted(halted), .Overflow(overflow)
    );

    function automatic logic [22:0] exp_data();
        return (m_q.size() != 0) ? m_q[0] : 23'h0;
    endfunction

    function automatic logic [15:0] rand_ir();
        logic [15:0] v;
        v = 16'($urandom);
        if (v == 16'h5000) v = 16'h1;
        return v;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_halted = 0;
        m_ovf    = 0;
        m_prev   = 4'h0;
    endfunction

    // Applies the buffer's rules to the inputs present before the edge, then advances one cycle.
    task automatic tick();
        bit cap, pop;
        cap = (state == 4'h2) && (m_prev != 4'h2) && !m_halted;
        pop = (m_q.size() != 0) && rd_ready;
        if (clr) begin
            m_q.delete();
            m_halted = 0;
            m_ovf    = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (cap) begin
                if (m_q.size() == 16) begin
                    void'(m_q.pop_front());
                    m_ovf = 1;
                end
                m_q.push_back({pc, ir});
                if (ir == 16'h5000) m_halted = 1;
            end
        end
        m_prev = state;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 0; rd_ready = 0; state = 4'h0;
    endtask

    task automatic capture_one(input logic [6:0] p, input logic [15:0] i);
        state = 4'h2; pc = p; ir = i; tick();
        state = 4'h0; tick();
    endtask

    task automatic do_clear();
        idle_inputs(); clr = 1; tick(); clr = 0;
    endtask

    task automatic test_reset();
        reset = 0; idle_inputs(); pc = 0; ir = 0;
        model_reset();
        #12;
        checks += 5;
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h want=0", rd_valid); end
        if (rd_data !== 23'h0) begin failures++; $display("FAIL reset_data got=%0h want=0", rd_data); end
        if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
        if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0h want=0", halted); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0h want=0", overflow); end
        #1 reset = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        idle_inputs(); tick();
        state = 4'h2; pc = 7'h05; ir = 16'h1234; tick();
        state = 4'h3; tick();
        checks += 3;
        if (count !== 5'd1) begin failures++; $display("FAIL single_count got=%0d want=1", count); end
        if (rd_data !== 23'h05_1234) begin failures++; $display("FAIL single_data got=%h want=051234", rd_data); end
        if (rd_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0h want=1", rd_valid); end
        rd_ready = 1; tick(); rd_ready = 0;
        checks += 2;
        if (count !== 5'd0) begin failures++; $display("FAIL single_drain_count got=%0d want=0", count); end
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL single_drain_valid got=%0h want=0", rd_valid); end
    endtask

    task automatic test_long_decode();
        do_clear();
        state = 4'h2; pc = 7'h11; ir = 16'hBEEF;
        for (int k = 0; k < 5; k++) tick();
        state = 4'h0; tick();
        checks += 2;
        if (count !== 5'd1) begin failures++; $display("FAIL long_decode_count got=%0d want=1", count); end
        if (rd_data !== 23'h11_BEEF) begin failures++; $display("FAIL long_decode_data got=%h want=11beef", rd_data); end
    endtask

    task automatic test_overflow();
        logic [22:0] last;
        do_clear();
        for (int k = 0; k < 18; k++) capture_one(7'(k), rand_ir());
        checks += 3;
        if (count !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d want=16", count); end
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0h want=1", overflow); end
        if (rd_data[22:16] !== 7'd2) begin failures++; $display("FAIL ovf_first_pc got=%0d want=2", rd_data[22:16]); end
        last = 23'h0;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (rd_data !== exp_data()) begin failures++; $display("FAIL ovf_read%0d got=%h want=%h", k, rd_data, exp_data()); end
            last = rd_data;
            rd_ready = 1; tick(); rd_ready = 0;
        end
        checks += 2;
        if (last[22:16] !== 7'd17) begin failures++; $display("FAIL ovf_last_pc got=%0d want=17", last[22:16]); end
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%0h want=0", rd_valid); end
    endtask

    task automatic test_full_cap_pop();
        logic [22:0] oldest;
        do_clear();
        for (int k = 0; k < 16; k++) capture_one(7'(k + 32), rand_ir());
        oldest = exp_data();
        state = 4'h2; pc = 7'h7F; ir = 16'hCAFE; rd_ready = 1;
        checks++;
        if (rd_data !== oldest) begin failures++; $display("FAIL fullpop_data got=%h want=%h", rd_data, oldest); end
        tick();
        rd_ready = 0; state = 4'h0; tick();
        checks += 3;
        if (count !== 5'd16) begin failures++; $display("FAIL fullpop_count got=%0d want=16", count); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL fullpop_ovf got=%0h want=0", overflow); end
        if (rd_data[22:16] !== 7'd33) begin failures++; $display("FAIL fullpop_next_pc got=%0d want=33", rd_data[22:16]); end
    endtask

    task automatic test_halt_clr();
        logic [22:0] last;
        do_clear();
        capture_one(7'h01, 16'h0101);
        capture_one(7'h0A, 16'h5000);
        checks += 2;
        if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%0h want=1", halted); end
        if (count !== 5'd2) begin failures++; $display("FAIL halt_count got=%0d want=2", count); end
        for (int k = 0; k < 3; k++) capture_one(7'(k + 20), rand_ir());
        checks++;
        if (count !== 5'd2) begin failures++; $display("FAIL halt_frozen_count got=%0d want=2", count); end
        last = 23'h0;
        for (int k = 0; k < 2; k++) begin
            last = rd_data;
            rd_ready = 1; tick(); rd_ready = 0;
        end
        checks += 2;
        if (last !== 23'h0A_5000) begin failures++; $display("FAIL halt_last_entry got=%h want=0a5000", last); end
        if (halted !== 1'b1) begin failures++; $display("FAIL halt_after_read got=%0h want=1", halted); end
        capture_one(7'h30, 16'h3333);
        do_clear();
        checks += 2;
        if (count !== 5'd0) begin failures++; $display("FAIL clr_count got=%0d want=0", count); end
        if (halted !== 1'b0) begin failures++; $display("FAIL clr_halted got=%0h want=0", halted); end
        capture_one(7'h31, 16'h4444);
        checks++;
        if (rd_data !== 23'h31_4444) begin failures++; $display("FAIL clr_resume got=%h want=314444", rd_data); end
    endtask

    task automatic test_async_reset();
        do_clear();
        for (int k = 0; k < 20; k++) capture_one(7'(k), rand_ir());
        #2 reset = 0;
        #1;
        model_reset();
        checks += 5;
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%0h want=0", rd_valid); end
        if (rd_data !== 23'h0) begin failures++; $display("FAIL areset_data got=%h want=0", rd_data); end
        if (count !== 5'd0) begin failures++; $display("FAIL areset_count got=%0d want=0", count); end
        if (halted !== 1'b0) begin failures++; $display("FAIL areset_halted got=%0h want=0", halted); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL areset_overflow got=%0h want=0", overflow); end
        #2 reset = 1;
        @(posedge clk); #1;
        state = 4'h2; pc = 7'h44; ir = 16'h0A0A; tick();
        checks++;
        if (rd_data !== 23'h44_0A0A) begin failures++; $display("FAIL areset_entry got=%h want=440a0a", rd_data); end
        state = 4'h0; tick();
    endtask

    task automatic test_random();
        do_clear();
        for (int n = 0; n < 600; n++) begin
            state    = ($urandom_range(0, 2) == 0) ? 4'h2 : 4'($urandom_range(0, 15));
            pc       = 7'($urandom);
            ir       = ($urandom_range(0, 40) == 0) ? 16'h5000 : rand_ir();
            rd_ready = ($urandom_range(0, 3) == 0);
            clr      = ($urandom_range(0, 60) == 0);
            tick();
            checks += 5;
            if (count !== 5'(m_q.size())) begin failures++; $display("FAIL rand_count n=%0d got=%0d want=%0d", n, count, m_q.size()); end
            if (rd_valid !== (m_q.size() != 0)) begin failures++; $display("FAIL rand_valid n=%0d got=%0h", n, rd_valid); end
            if (rd_data !== exp_data()) begin failures++; $display("FAIL rand_data n=%0d got=%h want=%h", n, rd_data, exp_data()); end
            if (halted !== m_halted) begin failures++; $display("FAIL rand_halted n=%0d got=%0h want=%0h", n, halted, m_halted); end
            if (overflow !== m_ovf) begin failures++; $display("FAIL rand_overflow n=%0d got=%0h want=%0h", n, overflow, m_ovf); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_long_decode();
        test_overflow();
        test_full_cap_pop();
        test_halt_clr();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
